// File: rtl/tone_divider_pkg.sv
// Shared constants and helpers for the tone divider: minimum running divisor,
// default divisor width and the high-phase length function.
package tone_divider_pkg;

  localparam int MIN_DIV       = 2;
  localparam int DEFAULT_WIDTH = 16;

  // Number of high cycles in a period of d clocks.
  function automatic logic [31:0] half(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/tone_divider_if.sv
// Control/status bundle between the note sequencer (master) and the divider (slave).
interface tone_divider_if
  import tone_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             enable;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             clk_div;
  logic             tick;
  logic             pend_busy;

  modport master (
    output enable, div_val, div_load,
    input  clk_div, tick, pend_busy
  );

  modport slave (
    input  enable, div_val, div_load,
    output clk_div, tick, pend_busy
  );

endinterface

// File: rtl/tone_div_core.sv
// Phase counter and registered clk_div/tick generation. i_run is the run decision
// for the cycle after the coming edge; r_cnt always holds the phase being shown.
module tone_div_core
  import tone_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_act_div,
  input  logic             i_run,
  output logic             o_active,
  output logic             o_period_end,
  output logic             o_clk_div,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic             r_active;
  logic             r_clk_div;
  logic             r_tick;

  assign o_active     = r_active;
  assign o_period_end = r_active && (r_cnt == i_act_div - WIDTH'(1));
  assign o_clk_div    = r_clk_div;
  assign o_tick       = r_tick;

  // Coming out of idle or off the last phase both restart at phase 0.
  always_comb begin
    w_cnt_next = '0;
    if (i_run && r_active && !o_period_end) begin
      w_cnt_next = r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_clk_div <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_active  <= i_run;
      r_clk_div <= i_run && (32'(w_cnt_next) < half(32'(i_act_div)));
      r_tick    <= i_run && (w_cnt_next == '0);
    end
  end

endmodule

// File: rtl/tone_divider.sv
// Glitch-free programmable tone divider: holds the active and pending divisors
// and decides at each edge whether the phase counter runs in the next cycle.
module tone_divider
  import tone_divider_pkg::*;
#(
  parameter int          WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  tone_divider_if.slave  bus
);

  localparam logic [WIDTH-1:0] L_MIN_DIV = WIDTH'(MIN_DIV);

  logic [WIDTH-1:0] r_act_div;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pend_valid;
  logic [WIDTH-1:0] w_act_next;
  logic [WIDTH-1:0] w_pend_div_next;
  logic             w_pend_valid_next;
  logic             w_run_next;
  logic             w_active;
  logic             w_period_end;
  logic             w_clk_div;
  logic             w_tick;

  // A fresh load always beats an older pending value when the divisor may change.
  always_comb begin
    w_act_next        = r_act_div;
    w_pend_div_next   = r_pend_div;
    w_pend_valid_next = r_pend_valid;
    w_run_next        = 1'b0;
    if (!bus.enable || w_period_end) begin
      if (bus.div_load) begin
        w_act_next = bus.div_val;
      end else if (r_pend_valid) begin
        w_act_next = r_pend_div;
      end
      w_pend_valid_next = 1'b0;
      w_run_next        = bus.enable && (w_act_next >= L_MIN_DIV);
    end else if (!w_active) begin
      if (bus.div_load) begin
        w_act_next = bus.div_val;
      end
      w_run_next = (r_act_div >= L_MIN_DIV);
    end else begin
      if (bus.div_load) begin
        w_pend_div_next   = bus.div_val;
        w_pend_valid_next = 1'b1;
      end
      w_run_next = (r_act_div >= L_MIN_DIV);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_div    <= WIDTH'(RESET_DIV);
      r_pend_div   <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_act_div    <= w_act_next;
      r_pend_div   <= w_pend_div_next;
      r_pend_valid <= w_pend_valid_next;
    end
  end

  tone_div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_act_div    (r_act_div),
    .i_run        (w_run_next),
    .o_active     (w_active),
    .o_period_end (w_period_end),
    .o_clk_div    (w_clk_div),
    .o_tick       (w_tick)
  );

  assign bus.clk_div   = w_clk_div;
  assign bus.tick      = w_tick;
  assign bus.pend_busy = r_pend_valid;

endmodule

// File: doc/tone_divider.md
# tone_divider

Parametrised, glitch-free programmable clock divider for the tone generation path of the music player. It is the successor to the fixed 4-bit 50%-duty divider: divisor width is a parameter, odd divisors are supported, and divisor changes apply only at period boundaries so notes change without runt pulses. A divisor below 2 mutes the output for rests. A per-period tick strobe is provided for the note sequencer.

## Interface
- WIDTH, 16, divisor width in bits; legal range 2..32.
- RESET_DIV, 0, active divisor after reset; 0 means muted.
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  run/mute control; low forces silence.
- div_val  input  WIDTH  requested divisor D (output period in clk cycles).
- div_load  input  1  one-cycle strobe; captures div_val.
- clk_div  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse marking the start of each clk_div period.
- pend_busy  output  1  high while a captured divisor waits for a period boundary.

## Operation
- State: act_div (WIDTH), pend_div (WIDTH), pend_valid, cnt (WIDTH), and registered clk_div and tick.
- Running means enable=1 and act_div ≥ 2. Otherwise the block is idle: cnt=0, clk_div=0, tick=0.
- Period: cnt steps 0..act_div−1 and wraps. Phase k = cnt value.
  - clk_div=1 for k < floor(act_div/2), otherwise 0.
  - Even D gives exactly 50% duty. Odd D gives a high phase one cycle shorter than the low phase (D=5: 2 high, 3 low).
- tick=1 exactly when k=0.
- Load while running: div_load sets pend_div=div_val and pend_valid=1.
  - A second load before the boundary overwrites pend_div. The last write wins.
  - At the period-end cycle (k=act_div−1): if pend_valid, then act_div←pend_div and pend_valid←0. cnt always wraps to 0.
- Load on the period-end cycle itself: div_val goes directly to act_div for the next period. The pending path is bypassed, and pend_busy does not assert.
- Load while idle: act_div←div_val at the next edge. pend_busy stays 0.
- Loaded value 0 or 1: the block goes idle at that boundary. The current period always completes first.
- enable falling: goes idle at the next edge (immediate mute, no period completion). Any pending value is applied to act_div immediately.
- enable rising with act_div ≥ 2: starts at k=0.
- pend_busy = pend_valid.
- Widths: all comparisons are unsigned at WIDTH bits. floor(D/2) = D>>1. cnt never exceeds act_div−1.

## Timing
- Reset (asynchronous assert): clk_div=0, tick=0, pend_busy=0, cnt=0, act_div=RESET_DIV, pend_div=0, pend_valid=0. Outputs go low immediately on reset assertion.
- Start latency: from the first posedge sampling enable=1 with act_div ≥ 2, clk_div and tick rise after that same edge (1 cycle).
- Load latency when idle: the first clk_div rise occurs 2 edges after the div_load sample.
- Divisor change: the new period begins on the edge after the old period's last cycle. There is no partial or runt pulse.
- Reset mid-period: abandons the period. After release, the block restarts from k=0 using RESET_DIV.
- Throughput: div_load is accepted every cycle. No backpressure.

## Structure
- Package tone_divider_pkg holds:
  - MIN_DIV=2.
  - Default WIDTH.
  - Helper function half(d)=d>>1.
- One sub-module, tone_div_core: counter, phase compare, and tick/clk_div registers, driven by act_div and a run flag.
- The top level holds act_div, pend_div, pend_valid, the boundary/bypass logic, and enable handling.

## Test plan
- Reset held 200 ns with RESET_DIV=0 -> clk_div=0, tick=0, pend_busy=0 throughout; outputs stay low after release.
- Load D=2, then D=4, D=8, D=10, with enable=1 -> measured periods 2/4/8/10 cycles; high times 1/2/4/5; one tick per period, coincident with each clk_div rise.
- Load D=5, then D=7 -> high/low = 2/3 and 3/4 cycles; periods exact.
- Running D=10; load D=4 at k=3, then D=6 at k=6 -> pend_busy high from k=4 to the boundary; the next period is 6 cycles; no pulse shorter than 3 cycles.
- Running D=8; load D=0 -> the current period completes, then clk_div stays 0 and no ticks occur. Load D=4 -> restarts 2 edges later.
- WIDTH=8 with D=255; deassert enable at k=100, and separately assert rst_n low at k=50 -> clk_div=0 on the next edge (on reset: immediately); after re-enable, or after release with RESET_DIV=4, periods are exact from k=0.
